// File: rtl/router_egress_drain.sv
// ---------------------------------------------------------------------------
// router_egress_drain
//
// Read-side consumer of one router output FIFO. Pulls bytes with
// fifo_read_enb, captures the registered FIFO output one cycle later, frames
// the bytes into packets (header / payload / parity) and streams them to the
// egress port over a valid/ready handshake. Packet parity is checked on the
// parity byte. If the downstream port holds off for TIMEOUT cycles the block
// pulses soft_reset_out, which also clears the upstream FIFO, and drops the
// rest of the packet.
//
// Optional feature macro: PKT_STATS_EN
//   defined   -> pkt_count / err_count are saturating 16-bit statistics
//   undefined -> both outputs are tied to 0 and no counter flops exist
//
// Ports
//   clock           in   single clock, all logic on posedge
//   resetn          in   asynchronous active-low reset
//   fifo_empty      in   FIFO empty flag
//   fifo_data       in   FIFO data_out, valid the cycle after a read strobe
//   fifo_read_enb   out  FIFO read strobe
//   soft_reset_out  out  1-cycle timeout pulse to the FIFO soft reset
//   dout            out  egress byte
//   dout_valid      out  dout holds a valid byte
//   dout_ready      in   downstream accepts dout this cycle
//   pkt_start       out  dout is a header byte
//   pkt_end         out  dout is a parity byte
//   parity_err      out  with pkt_end: packet parity mismatch
//   pkt_count       out  packets completed
//   err_count       out  parity errors plus timeouts
//
// Framing FSM (advances once per captured byte)
//   state       | meaning
//   ST_HDR      | next captured byte is a header; load length and parity
//   ST_PAYLOAD  | capturing payload bytes, rem counts what is left
//   ST_PARITY   | next captured byte is the parity byte; compare and finish
// ---------------------------------------------------------------------------
module router_egress_drain #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read_enb,
    output logic             soft_reset_out,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             pkt_start,
    output logic             pkt_end,
    output logic             parity_err,
    output logic [15:0]      pkt_count,
    output logic [15:0]      err_count
);

    // buffer entry layout: {byte, start, end, perr}
    localparam int EW = WIDTH + 3;
    localparam logic [4:0] TC_LAST = 5'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [5:0]     rem, rem_nxt;
    logic [WIDTH-1:0] par, par_nxt;

    logic           run;
    logic           inflight;
    logic [EW-1:0]  slot0, slot1;
    logic [1:0]     occ;
    logic [4:0]     tcnt;
    logic           srst_q;

    logic           xfer;
    logic           stall;
    logic           fire;
    logic           cap;
    logic [2:0]     load;
    logic           new_start, new_end, new_perr;
    logic [EW-1:0]  new_entry;

    // -----------------------------------------------------------------------
    // Handshake, read issue and timeout detection
    // -----------------------------------------------------------------------
    assign dout_valid     = (occ != 2'd0);
    assign dout           = slot0[EW-1:3];
    assign pkt_start      = slot0[2];
    assign pkt_end        = slot0[1];
    assign parity_err     = slot0[0];
    assign soft_reset_out = srst_q;

    assign xfer  = dout_valid & dout_ready;
    assign stall = dout_valid & ~dout_ready;
    assign fire  = stall & (tcnt == TC_LAST);
    assign cap   = inflight;

    // Occupancy is counted after this cycle's departure so a full-rate
    // stream (capture + transfer every cycle) keeps one read in flight.
    assign load = {1'b0, occ} - {2'b0, xfer} + {2'b0, inflight};

    // run holds reads off until the first edge after reset is released
    assign fifo_read_enb = run & ~fifo_empty & ~srst_q & (load < 3'd2);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run      <= 1'b0;
            inflight <= 1'b0;
            srst_q   <= 1'b0;
            tcnt     <= 5'd0;
        end else begin
            run    <= 1'b1;
            srst_q <= fire;
            // the read outstanding at the flush edge is dropped with the FIFO
            inflight <= fire ? 1'b0 : fifo_read_enb;
            if (fire || !dout_valid || xfer)
                tcnt <= 5'd0;
            else if (stall)
                tcnt <= 5'(tcnt + 5'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_HDR;
            rem   <= 6'd0;
            par   <= '0;
        end else if (fire) begin
            state <= ST_HDR;
            rem   <= 6'd0;
            par   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            par   <= par_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        par_nxt   = par;
        if (cap) begin
            case (state)
                ST_HDR: begin
                    rem_nxt   = fifo_data[7:2];
                    par_nxt   = fifo_data;
                    state_nxt = (fifo_data[7:2] == 6'd0) ? ST_PARITY : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    par_nxt = par ^ fifo_data;
                    rem_nxt = 6'(rem - 6'd1);
                    if (rem == 6'd1)
                        state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    state_nxt = ST_HDR;
                end
                default: begin
                    state_nxt = ST_HDR;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM: flags attached to the byte being captured
    // -----------------------------------------------------------------------
    always_comb begin
        new_start = 1'b0;
        new_end   = 1'b0;
        new_perr  = 1'b0;
        case (state)
            ST_HDR:    new_start = 1'b1;
            ST_PARITY: begin
                new_end  = 1'b1;
                new_perr = (par != fifo_data);
            end
            default: begin
                new_start = 1'b0;
            end
        endcase
    end

    assign new_entry = {fifo_data, new_start, new_end, new_perr};

    // -----------------------------------------------------------------------
    // Two-entry output buffer, slot0 is the head
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (fire) begin
            occ   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (cap && xfer) begin
            if (occ == 2'd1) begin
                slot0 <= new_entry;
            end else begin
                slot0 <= slot1;
                slot1 <= new_entry;
            end
        end else if (cap) begin
            if (occ == 2'd0)
                slot0 <= new_entry;
            else
                slot1 <= new_entry;
            occ <= 2'(occ + 2'd1);
        end else if (xfer) begin
            slot0 <= slot1;
            occ   <= 2'(occ - 2'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Packet statistics
    // -----------------------------------------------------------------------
`ifdef PKT_STATS_EN
    logic pkt_inc;
    logic err_inc;

    // the buffer is empty during the pulse, so both sources never coincide
    assign pkt_inc = xfer & pkt_end;
    assign err_inc = (xfer & pkt_end & parity_err) | srst_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count <= 16'd0;
            err_count <= 16'd0;
        end else begin
            if (pkt_inc && pkt_count != 16'hFFFF)
                pkt_count <= 16'(pkt_count + 16'd1);
            if (err_inc && err_count != 16'hFFFF)
                err_count <= 16'(err_count + 16'd1);
        end
    end
`else
    assign pkt_count = 16'd0;
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_router_egress_drain.sv
module tb_router_egress_drain;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        dout_ready = 1'b0;
    logic        fifo_read_enb;
    logic        soft_reset_out;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        pkt_start;
    logic        pkt_end;
    logic        parity_err;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    router_egress_drain #(.WIDTH(8), .TIMEOUT(30)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_read_enb  (fifo_read_enb),
        .soft_reset_out (soft_reset_out),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .pkt_start      (pkt_start),
        .pkt_end        (pkt_end),
        .parity_err     (parity_err),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    int rmode = 0;
    int stall_run = 0;

    logic [7:0]  fq[$];     // upstream FIFO contents
    logic [10:0] sbq[$];    // expected egress stream {byte,start,end,perr}
    int          xfer_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Upstream router FIFO: registered data_out, cleared by soft reset
    always @(posedge clock) begin
        cyc++;
        if (soft_reset_out) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else if (fifo_read_enb && fq.size() > 0) begin
            fifo_data  <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Downstream ready pattern: 0 always, 1 never, 2 toggle, 3 random bounded
    always @(posedge clock) begin
        #1;
        case (rmode)
            0: dout_ready = 1'b1;
            1: dout_ready = 1'b0;
            2: dout_ready = ~dout_ready;
            default: begin
                if (stall_run >= 8) dout_ready = 1'b1;
                else dout_ready = ($urandom_range(0, 9) < 7);
                stall_run = dout_ready ? 0 : stall_run + 1;
            end
        endcase
    end

    // Scoreboard on every transfer
    always @(negedge clock) begin
        logic [10:0] e;
        if (resetn) begin
            if (fifo_read_enb) check("rd_when_empty", fifo_empty, 0);
            if (dout_valid && dout_ready) begin
                xfer_cyc.push_back(cyc);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    if (e[1]) begin
                        exp_pkt++;
                        if (e[0]) exp_err++;
                    end
                end else begin
                    e = 11'h7FF;  // start and end together never occur
                end
                check("xfer", {dout, pkt_start, pkt_end, parity_err}, e);
            end
        end
    end

    // Load one packet into the FIFO and derive its expected framing
    task automatic push_pkt(input logic [7:0] pk[$]);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < pk.size(); i++) begin
            fq.push_back(pk[i]);
            if (i == 0)
                sbq.push_back({pk[i], 3'b100});
            else if (i == pk.size() - 1)
                sbq.push_back({pk[i], 2'b01, (x != pk[i])});
            else
                sbq.push_back({pk[i], 3'b000});
            if (i != pk.size() - 1) x = x ^ pk[i];
        end
        fifo_empty = 1'b0;
    endtask

    task automatic rand_pkt(input int len, input bit corrupt);
        logic [7:0] pk[$];
        logic [7:0] x;
        pk.push_back({len[5:0], 2'($urandom_range(0, 3))});
        for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
        x = 8'h00;
        foreach (pk[i]) x = x ^ pk[i];
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        pk.push_back(x);
        push_pkt(pk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sbq.size() != 0 || fq.size() != 0 || dout_valid) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (n >= budget) check("drain_timeout", sbq.size(), 0);
        repeat (3) @(posedge clock);
        #2;
    endtask

    task automatic check_stats(input string tag);
`ifdef PKT_STATS_EN
        check({tag, "_pkt"}, pkt_count, exp_pkt);
        check({tag, "_err"}, err_count, exp_err);
`else
        check({tag, "_pkt"}, pkt_count, 0);
        check({tag, "_err"}, err_count, 0);
`endif
    endtask

    initial begin
        logic [7:0] pk[$];
        int tv, ts, pulses, k, nbytes;

        // 1: reset with data pending
        rmode = 0;
        repeat (2) @(posedge clock);
        #2;
        pk = '{8'h04, 8'hAA, 8'hAE};
        push_pkt(pk);
        repeat (3) @(negedge clock);
        check("rst_outs", {fifo_read_enb, soft_reset_out, dout_valid, pkt_start,
                           pkt_end, parity_err, dout}, 0);
        check("rst_cnt", {pkt_count, err_count}, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("rd_after_rst", fifo_read_enb, 1);
        check("valid_after_rst", dout_valid, 0);
        wait_drain(200);
        check_stats("t1");

        // 2: good packet at full rate
        xfer_cyc.delete();
        pk = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        push_pkt(pk);
        wait_drain(200);
        check("t2_nbytes", xfer_cyc.size(), 5);
        if (xfer_cyc.size() == 5) check("t2_consec", xfer_cyc[4] - xfer_cyc[0], 4);
        check_stats("t2");

        // 3: corrupted parity
        pk = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h00};
        push_pkt(pk);
        wait_drain(200);
        check_stats("t3");

        // 4: downstream stalls -> timeout
        rmode = 1;
        @(posedge clock);
        #2;
        pk = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
        push_pkt(pk);
        tv = -1; ts = -1; pulses = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clock);
            if (dout_valid && tv < 0) tv = k;
            if (ts >= 0 && k == ts + 1) check("t4_valid_after", dout_valid, 0);
            if (soft_reset_out) begin
                pulses++;
                if (ts < 0) ts = k;
                check("t4_rd_in_pulse", fifo_read_enb, 0);
                sbq.delete();
                exp_err++;
            end
        end
        check("t4_pulses", pulses, 1);
        check("t4_delay", ts - tv, 30);
        check("t4_fifo_cleared", fq.size(), 0);
        rmode = 0;
        @(posedge clock);
        #2;
        rand_pkt(2, 0);  // must frame from a header again
        wait_drain(200);
        check_stats("t4");

        // 5: zero-length packet
        pk = '{8'h00, 8'h00};
        push_pkt(pk);
        wait_drain(200);
        check_stats("t5");

        // 6: ready toggling across two back-to-back packets
        rmode = 2;
        xfer_cyc.delete();
        @(posedge clock);
        #2;
        rand_pkt(5, 0);
        rand_pkt(3, 1);
        wait_drain(400);
        check("t6_nbytes", xfer_cyc.size(), 7 + 5);
        check_stats("t6");

        // random traffic against random backpressure
        rmode = 3;
        xfer_cyc.delete();
        nbytes = 0;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, 12);
            nbytes += len + 2;
            rand_pkt(len, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(1, 6)) @(posedge clock);
            #2;
        end
        wait_drain(8000);
        check("rand_nbytes", xfer_cyc.size(), nbytes);
        check_stats("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
